// File: rtl/video_timing_pattern_if.sv
// Raster output bundle of the video timing/pattern generator.
// The generator drives the master side; overlay/encoder logic sits on the slave side.
interface video_timing_pattern_if #(
    parameter int COLSPC = 10,
    parameter int CORDW  = 12
);
    logic [1:0]        pattern_sel;
    logic              video_enable;
    logic              hsync;
    logic              vsync;
    logic [COLSPC-1:0] red;
    logic [COLSPC-1:0] green;
    logic [COLSPC-1:0] blue;
    logic [CORDW-1:0]  sx;
    logic [CORDW-1:0]  sy;
    logic              frame_start;
    logic              line_start;

    // No flow control: one pixel per clock, always valid, never back-pressured.
    modport master (
        input  pattern_sel,
        output video_enable, hsync, vsync, red, green, blue, sx, sy, frame_start, line_start
    );

    modport slave (
        output pattern_sel,
        input  video_enable, hsync, vsync, red, green, blue, sx, sy, frame_start, line_start
    );
endinterface

// File: rtl/video_timing_pattern.sv
// Pixel-clock raster generator: counters, syncs, enable, test patterns and strobes,
// all registered together from (hc,vc) so nothing skews at the encoder input.
module video_timing_pattern #(
    parameter int COLSPC   = 10,
    parameter int CORDW    = 12,
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit H_POL    = 1'b1,
    parameter bit V_POL    = 1'b1
) (
    input  logic                   video_clk_pix,
    input  logic                   video_rst_pix,
    video_timing_pattern_if.master vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int EXTW    = CORDW + COLSPC + 6;

    localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] H_ACT_C  = CORDW'(H_ACTIVE);
    localparam logic [CORDW-1:0] V_ACT_C  = CORDW'(V_ACTIVE);
    localparam logic [CORDW-1:0] HS_BEG_C = CORDW'(H_ACTIVE + H_FP);
    localparam logic [CORDW-1:0] HS_END_C = CORDW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CORDW-1:0] VS_BEG_C = CORDW'(V_ACTIVE + V_FP);
    localparam logic [CORDW-1:0] VS_END_C = CORDW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CORDW+2:0] BAR_DIV  = (CORDW+3)'(H_ACTIVE);

    if (H_TOTAL - 1 >= (1 << CORDW)) begin : g_bad_h
        $error("CORDW too narrow for H_TOTAL");
    end
    if (V_TOTAL - 1 >= (1 << CORDW)) begin : g_bad_v
        $error("CORDW too narrow for V_TOTAL");
    end
    if (H_SYNC <= 0 || V_SYNC <= 0) begin : g_bad_sync
        $error("H_SYNC and V_SYNC must be non-zero");
    end

    logic [CORDW-1:0]  hc_q, hc_d, vc_q, vc_d;
    logic [1:0]        pat_q, pat_d;
    logic              en_q, en_d, hs_q, hs_d, vs_q, vs_d;
    logic [COLSPC-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic [CORDW-1:0]  sx_q, sx_d, sy_q, sy_d;
    logic              fs_q, fs_d, ls_q, ls_d;

    logic              origin, active, hs_act, vs_act;
    logic [CORDW+2:0]  bar_quot;
    logic [2:0]        bar_rgb;
    logic [EXTW-1:0]   hc_ext, vc_ext;
    logic [COLSPC-1:0] pix_r, pix_g, pix_b;

    always_comb begin
        hc_d = hc_q + CORDW'(1);
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + CORDW'(1);
        end
    end

    // The frame's pattern is latched at the origin and the origin pixel already uses it.
    always_comb begin
        origin = (hc_q == '0) && (vc_q == '0);
        pat_d  = origin ? vid.pattern_sel : pat_q;
        active = (hc_q < H_ACT_C) && (vc_q < V_ACT_C);
        hs_act = (hc_q >= HS_BEG_C) && (hc_q < HS_END_C);
        vs_act = (vc_q >= VS_BEG_C) && (vc_q < VS_END_C);
    end

    always_comb begin
        hc_ext   = EXTW'(hc_q);
        vc_ext   = EXTW'(vc_q);
        bar_quot = {hc_q, 3'b000} / BAR_DIV;
        case (bar_quot[2:0])
            3'd0:    bar_rgb = 3'b111;
            3'd1:    bar_rgb = 3'b110;
            3'd2:    bar_rgb = 3'b011;
            3'd3:    bar_rgb = 3'b010;
            3'd4:    bar_rgb = 3'b101;
            3'd5:    bar_rgb = 3'b100;
            3'd6:    bar_rgb = 3'b001;
            default: bar_rgb = 3'b000;
        endcase
        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
        case (pat_d)
            2'b01: begin
                pix_r = {COLSPC{bar_rgb[2]}};
                pix_g = {COLSPC{bar_rgb[1]}};
                pix_b = {COLSPC{bar_rgb[0]}};
            end
            2'b10: begin
                pix_r = {COLSPC{hc_ext[5] ^ vc_ext[5]}};
                pix_g = pix_r;
                pix_b = pix_r;
            end
            2'b11: begin
                pix_r = hc_ext[COLSPC-1:0];
                pix_g = vc_ext[COLSPC-1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        en_d = active;
        hs_d = hs_act ? H_POL : !H_POL;
        vs_d = vs_act ? V_POL : !V_POL;
        r_d  = active ? pix_r : '0;
        g_d  = active ? pix_g : '0;
        b_d  = active ? pix_b : '0;
        sx_d = hc_q;
        sy_d = vc_q;
        fs_d = origin;
        ls_d = (hc_q == '0);
    end

    always_ff @(posedge video_clk_pix or posedge video_rst_pix) begin
        if (video_rst_pix) begin
            hc_q  <= '0;
            vc_q  <= '0;
            pat_q <= 2'b01;
            en_q  <= 1'b0;
            hs_q  <= !H_POL;
            vs_q  <= !V_POL;
            r_q   <= '0;
            g_q   <= '0;
            b_q   <= '0;
            sx_q  <= '0;
            sy_q  <= '0;
            fs_q  <= 1'b0;
            ls_q  <= 1'b0;
        end else begin
            hc_q  <= hc_d;
            vc_q  <= vc_d;
            pat_q <= pat_d;
            en_q  <= en_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            r_q   <= r_d;
            g_q   <= g_d;
            b_q   <= b_d;
            sx_q  <= sx_d;
            sy_q  <= sy_d;
            fs_q  <= fs_d;
            ls_q  <= ls_d;
        end
    end

    assign vid.video_enable = en_q;
    assign vid.hsync        = hs_q;
    assign vid.vsync        = vs_q;
    assign vid.red          = r_q;
    assign vid.green        = g_q;
    assign vid.blue         = b_q;
    assign vid.sx           = sx_q;
    assign vid.sy           = sy_q;
    assign vid.frame_start  = fs_q;
    assign vid.line_start   = ls_q;
endmodule

// File: tb/tb_video_timing_pattern.sv
// Directed bench: a 24x12 raster for timing, a 72x44 raster (active-low syncs) for
// pattern switching, and the default 720p raster for bar colours and line timing.
module tb_video_timing_pattern;
  localparam int S_FRAME = 24 * 12;
  localparam int M_FRAME = 72 * 44;

  logic clk = 1'b0;
  logic rst_s, rst_m, rst_l;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  video_timing_pattern_if #(.COLSPC(10), .CORDW(12)) if_s ();
  video_timing_pattern_if #(.COLSPC(10), .CORDW(12)) if_m ();
  video_timing_pattern_if #(.COLSPC(10), .CORDW(12)) if_l ();

  video_timing_pattern #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_s (.video_clk_pix(clk), .video_rst_pix(rst_s), .vid(if_s));

  video_timing_pattern #(
    .H_ACTIVE(64), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(40), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0)
  ) dut_m (.video_clk_pix(clk), .video_rst_pix(rst_m), .vid(if_m));

  video_timing_pattern dut_l (.video_clk_pix(clk), .video_rst_pix(rst_l), .vid(if_l));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_small_reset(input string tag);
    check({tag, "_en"}, 32'(if_s.video_enable), 32'd0);
    check({tag, "_hs"}, 32'(if_s.hsync), 32'd0);
    check({tag, "_vs"}, 32'(if_s.vsync), 32'd0);
    check({tag, "_rgb"}, 32'(if_s.red | if_s.green | if_s.blue), 32'd0);
    check({tag, "_sxy"}, 32'(if_s.sx | if_s.sy), 32'd0);
    check({tag, "_fs"}, 32'(if_s.frame_start), 32'd0);
    check({tag, "_ls"}, 32'(if_s.line_start), 32'd0);
  endtask

  task automatic check_small_origin(input string tag);
    check({tag, "_fs"}, 32'(if_s.frame_start), 32'd1);
    check({tag, "_ls"}, 32'(if_s.line_start), 32'd1);
    check({tag, "_en"}, 32'(if_s.video_enable), 32'd1);
    check({tag, "_sx"}, 32'(if_s.sx), 32'd0);
    check({tag, "_sy"}, 32'(if_s.sy), 32'd0);
    check({tag, "_red"}, 32'(if_s.red), 32'd1023);
  endtask

  // Clock/reset and directed sequence.
  initial begin
    int hs_bad, vs_bad, hs_cnt, vs_cnt, en_cnt, xy_bad, blank_bad, fs_gap, hs_first;
    int ex, ey;
    rst_s = 1'b1;
    rst_m = 1'b1;
    rst_l = 1'b1;
    if_s.pattern_sel = 2'b01;
    if_m.pattern_sel = 2'b01;
    if_l.pattern_sel = 2'b01;
    repeat (3) @(negedge clk);
    check_small_reset("s_rst");
    check("m_rst_hs", 32'(if_m.hsync), 32'd1);
    check("m_rst_vs", 32'(if_m.vsync), 32'd1);

    // Small raster: one full frame of timing plus a mid-frame reset.
    hs_bad = 0; vs_bad = 0; hs_cnt = 0; vs_cnt = 0; en_cnt = 0;
    xy_bad = 0; blank_bad = 0; fs_gap = -1;
    rst_s = 1'b0;
    for (int c = 0; c <= S_FRAME + 5 * 24 + 5; c++) begin
      @(negedge clk);
      if (c == 0) check_small_origin("s_first");
      if (c < S_FRAME) begin
        ex = c % 24;
        ey = c / 24;
        if (32'(if_s.sx) != ex || 32'(if_s.sy) != ey) xy_bad++;
        if (if_s.hsync != (ex >= 18 && ex <= 20)) hs_bad++;
        if (if_s.vsync != (ey >= 9 && ey <= 10)) vs_bad++;
        if (if_s.hsync) hs_cnt++;
        if (if_s.vsync) vs_cnt++;
        if (if_s.video_enable) en_cnt++;
        if (!if_s.video_enable && (if_s.red | if_s.green | if_s.blue) != '0) blank_bad++;
      end
      if (c > 0 && if_s.frame_start && fs_gap < 0) fs_gap = c;
    end
    check("s_fs_gap", 32'(fs_gap), 32'(S_FRAME));
    check("s_coord_bad", 32'(xy_bad), 32'd0);
    check("s_hs_bad", 32'(hs_bad), 32'd0);
    check("s_vs_bad", 32'(vs_bad), 32'd0);
    check("s_hs_cnt", 32'(hs_cnt), 32'd36);
    check("s_vs_cnt", 32'(vs_cnt), 32'd48);
    check("s_en_cnt", 32'(en_cnt), 32'd128);
    check("s_blank_rgb", 32'(blank_bad), 32'd0);
    // Pixel (5,5) of frame 1: bar 2 is cyan.
    check("s_pre_rst_green", 32'(if_s.green), 32'd1023);
    check("s_pre_rst_red", 32'(if_s.red), 32'd0);
    #2 rst_s = 1'b1;
    #1 check_small_reset("s_async");
    repeat (3) @(negedge clk);
    rst_s = 1'b0;
    @(negedge clk);
    check_small_origin("s_restart");

    // 720p: first line bar colours, blanking and horizontal timing.
    hs_cnt = 0; hs_first = -1;
    rst_l = 1'b0;
    for (int c = 0; c <= 1650; c++) begin
      @(negedge clk);
      if (c < 1650 && if_l.hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = c;
      end
      if (c == 0) begin
        check("l_fs0", 32'(if_l.frame_start), 32'd1);
        check("l_white_r", 32'(if_l.red), 32'd1023);
        check("l_white_b", 32'(if_l.blue), 32'd1023);
      end
      if (c == 160) begin
        check("l_yel_r", 32'(if_l.red), 32'd1023);
        check("l_yel_g", 32'(if_l.green), 32'd1023);
        check("l_yel_b", 32'(if_l.blue), 32'd0);
      end
      if (c == 1279) begin
        check("l_black_rgb", 32'(if_l.red | if_l.green | if_l.blue), 32'd0);
        check("l_1279_en", 32'(if_l.video_enable), 32'd1);
      end
      if (c == 1280) begin
        check("l_blank_en", 32'(if_l.video_enable), 32'd0);
        check("l_blank_rgb", 32'(if_l.red | if_l.green | if_l.blue), 32'd0);
      end
      if (c == 1650) begin
        check("l_ls_line1", 32'(if_l.line_start), 32'd1);
        check("l_sy_line1", 32'(if_l.sy), 32'd1);
        check("l_fs_line1", 32'(if_l.frame_start), 32'd0);
      end
    end
    check("l_hs_width", 32'(hs_cnt), 32'd40);
    check("l_hs_first", 32'(hs_first), 32'd1390);
    rst_l = 1'b1;

    // Medium raster: pattern changes only take effect at the next frame.
    rst_m = 1'b0;
    for (int c = 0; c <= 2 * M_FRAME + 3 * 72 + 5; c++) begin
      @(negedge clk);
      if (c == 65) check("m_hs_idle", 32'(if_m.hsync), 32'd1);
      if (c == 66) check("m_hs_act", 32'(if_m.hsync), 32'd0);
      if (c == 20 * 72) if_m.pattern_sel = 2'b10;
      if (c == 30 * 72 + 32) begin
        check("m_bars_kept_r", 32'(if_m.red), 32'd1023);
        check("m_bars_kept_g", 32'(if_m.green), 32'd0);
      end
      if (c == M_FRAME) check("m_fs1", 32'(if_m.frame_start), 32'd1);
      if (c == M_FRAME + 32) check("m_chk_32_0", 32'(if_m.red), 32'd1023);
      if (c == M_FRAME + 100) if_m.pattern_sel = 2'b11;
      if (c == M_FRAME + 32 * 72) check("m_chk_0_32", 32'(if_m.green), 32'd1023);
      if (c == M_FRAME + 32 * 72 + 32) begin
        check("m_chk_32_32_r", 32'(if_m.red), 32'd0);
        check("m_chk_32_32_g", 32'(if_m.green), 32'd0);
      end
      if (c == 2 * M_FRAME + 3 * 72 + 5) begin
        check("m_grad_r", 32'(if_m.red), 32'd5);
        check("m_grad_g", 32'(if_m.green), 32'd3);
        check("m_grad_b", 32'(if_m.blue), 32'd0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
